vend_coin_frontend: RTL and testbench

Upstream input stage for the vending-machine FSM. It conditions three raw coin-sensor lines (nickel, dime, quarter) with a 2-FF synchronizer, a debouncer and a rising-edge detector. Each accepted coin is converted to a cent value and queued in a small FIFO. The FSM consumes the queue through a valid/ready handshake. Jams, overflows and coins inserted while disabled are reported and drive the coin-return flap.

---
 rtl/vend_pkg.sv | 24 ++
 rtl/coin_debounce.sv | 51 +++++
 rtl/vend_coin_frontend.sv | 104 ++++++++++
 tb/tb_vend_coin_frontend.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared constants for the vending coin front end: channel indices, cent values
// and the channel-to-value lookup used when a coin is queued.
package vend_pkg;

  localparam int COIN_NICKEL  = 0;
  localparam int COIN_DIME    = 1;
  localparam int COIN_QUARTER = 2;
  localparam int NUM_COINS    = 3;
  localparam int CENTS_W      = 5;

  localparam logic [CENTS_W-1:0] CENTS_NICKEL  = 5'd5;
  localparam logic [CENTS_W-1:0] CENTS_DIME    = 5'd10;
  localparam logic [CENTS_W-1:0] CENTS_QUARTER = 5'd25;

  function automatic logic [CENTS_W-1:0] coin_value(input logic [NUM_COINS-1:0] rise);
    logic [CENTS_W-1:0] val;
    val = '0;
    if (rise[COIN_QUARTER])     val = CENTS_QUARTER;
    else if (rise[COIN_DIME])   val = CENTS_DIME;
    else if (rise[COIN_NICKEL]) val = CENTS_NICKEL;
    return val;
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin sensor channel: 2-FF synchronizer, consecutive-cycle debouncer and a
// registered rising-edge pulse of the debounced level.
module coin_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic rise_o
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             stable_dly_q;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    cnt_inc  = cnt_q + CNT_W'(1);
    if (sync2_q != stable_q) begin
      if (cnt_inc == CNT_W'(DEB_CYCLES)) stable_d = sync2_q;
      else                               cnt_d    = cnt_inc;
    end
    rise_d = stable_q & ~stable_dly_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
      rise_q       <= 1'b0;
    end else begin
      sync1_q      <= raw_i;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
      rise_q       <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/vend_coin_frontend.sv
// Coin front end: conditions three sensors, classifies coin edges (jam, disabled,
// overflow, accept) and queues accepted cent values in a show-ahead FIFO.
module vend_coin_frontend
  import vend_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_COINS-1:0]          coin_raw,
  input  logic                          accept_en,
  input  logic                          coin_ready,
  input  logic                          clr_err,
  output logic                          coin_valid,
  output logic [CENTS_W-1:0]            coin_cents,
  output logic                          coin_reject,
  output logic                          jam_err,
  output logic                          ovf_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [NUM_COINS-1:0] rise;
  logic                 multi, pop, push, full;
  logic                 reject_d, jam_set, ovf_set;
  logic                 reject_q, jam_q, ovf_q;
  logic [CENTS_W-1:0]   push_val;
  logic [CENTS_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q, count_d;

  for (genvar g = 0; g < NUM_COINS; g++) begin : g_chan
    coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (coin_raw[g]),
      .rise_o (rise[g])
    );
  end

  assign coin_valid = (count_q != '0);
  assign full       = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop        = coin_valid & coin_ready;
  assign push_val   = coin_value(rise);

  // A full FIFO still accepts the coin when the consumer frees a slot this cycle.
  always_comb begin
    push     = 1'b0;
    reject_d = 1'b0;
    jam_set  = 1'b0;
    ovf_set  = 1'b0;
    multi    = |(rise & (rise - NUM_COINS'(1)));
    if (multi) begin
      jam_set  = 1'b1;
      reject_d = 1'b1;
    end else if (|rise) begin
      if (!accept_en) begin
        reject_d = 1'b1;
      end else if (full && !pop) begin
        ovf_set  = 1'b1;
        reject_d = 1'b1;
      end else begin
        push = 1'b1;
      end
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      reject_q <= 1'b0;
      jam_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q  <= count_d;
      reject_q <= reject_d;
      jam_q    <= jam_set | (jam_q & ~clr_err);
      ovf_q    <= ovf_set | (ovf_q & ~clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_val;
  end

  assign coin_cents  = coin_valid ? mem_q[rd_ptr_q] : '0;
  assign coin_reject = reject_q;
  assign jam_err     = jam_q;
  assign ovf_err     = ovf_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_vend_coin_frontend.sv
// Bench for vend_coin_frontend: directed scenarios with literal expectations, then
// random sensor traffic checked every cycle against an event-level model.
module tb_vend_coin_frontend;

  localparam int DEB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] coin_raw;
  logic       accept_en, coin_ready, clr_err;
  logic       coin_valid, coin_reject, jam_err, ovf_err;
  logic [4:0] coin_cents;
  logic [2:0] fifo_count;

  vend_coin_frontend #(.DEB_CYCLES(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coin_raw   (coin_raw),
    .accept_en  (accept_en),
    .coin_ready (coin_ready),
    .clr_err    (clr_err),
    .coin_valid (coin_valid),
    .coin_cents (coin_cents),
    .coin_reject(coin_reject),
    .jam_err    (jam_err),
    .ovf_err    (ovf_err),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_rej = 0;

  // Model: raw is seen two cycles late; a level is accepted once DEB consecutive
  // samples disagree with it; an accepted 0->1 becomes a coin event one cycle
  // later and is classified on the following edge.
  int         m_q[$];
  bit         m_jam, m_ovf, m_reject;
  bit [2:0]   m_raw_d1, m_sync, m_rise, m_up, m_stable;
  bit [15:0]  m_hist [3];
  int         m_nsamp [3];
  int         cents_tab [3] = '{5, 10, 25};

  task automatic model_step();
    int  n, nr, val;
    bit  pop, push, rej, jset, oset, flip;
    bit  [2:0] new_up;
    if (!rst_n) begin
      m_q.delete();
      m_jam = 0; m_ovf = 0; m_reject = 0;
      m_raw_d1 = 0; m_sync = 0; m_rise = 0; m_up = 0; m_stable = 0;
      for (int c = 0; c < 3; c++) begin m_hist[c] = 0; m_nsamp[c] = 0; end
      return;
    end
    n = m_q.size();
    pop = (n != 0) && coin_ready;
    nr = $countones(m_rise);
    push = 0; rej = 0; jset = 0; oset = 0; val = 0;
    if (nr >= 2) begin jset = 1; rej = 1; end
    else if (nr == 1) begin
      for (int c = 0; c < 3; c++) if (m_rise[c]) val = cents_tab[c];
      if (!accept_en) rej = 1;
      else if (n == DEPTH && !pop) begin oset = 1; rej = 1; end
      else push = 1;
    end
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back(val);
    m_jam    = jset | (m_jam & !clr_err);
    m_ovf    = oset | (m_ovf & !clr_err);
    m_reject = rej;
    new_up = 0;
    for (int c = 0; c < 3; c++) begin
      m_hist[c] = {m_hist[c][14:0], m_sync[c]};
      if (m_nsamp[c] < 16) m_nsamp[c]++;
      flip = (m_nsamp[c] >= DEB);
      for (int k = 0; k < DEB; k++) if (m_hist[c][k] == m_stable[c]) flip = 0;
      if (flip) begin
        new_up[c]    = !m_stable[c];
        m_stable[c]  = !m_stable[c];
      end
    end
    m_rise   = m_up;
    m_up     = new_up;
    m_sync   = m_raw_d1;
    m_raw_d1 = coin_raw;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic compare();
    chk("m_valid",  int'(coin_valid),  (m_q.size() != 0) ? 1 : 0);
    chk("m_cents",  int'(coin_cents),  (m_q.size() != 0) ? m_q[0] : 0);
    chk("m_count",  int'(fifo_count),  m_q.size());
    chk("m_reject", int'(coin_reject), int'(m_reject));
    chk("m_jam",    int'(jam_err),     int'(m_jam));
    chk("m_ovf",    int'(ovf_err),     int'(m_ovf));
  endtask

  task automatic tick();
    @(negedge clk);
    n_rej += int'(coin_reject);
    if (rst_n) compare();
  endtask

  task automatic insert(input logic [2:0] mask);
    coin_raw = mask;
    repeat (10) tick();
    coin_raw = 3'b000;
    repeat (12) tick();
  endtask

  task automatic clear_errs();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"},  int'(coin_valid),  0);
    chk({tag, "_cents"},  int'(coin_cents),  0);
    chk({tag, "_count"},  int'(fifo_count),  0);
    chk({tag, "_reject"}, int'(coin_reject), 0);
    chk({tag, "_jam"},    int'(jam_err),     0);
    chk({tag, "_ovf"},    int'(ovf_err),     0);
  endtask

  int run [3];

  initial begin
    rst_n = 1'b0; coin_raw = 3'b000; accept_en = 1'b0; coin_ready = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    accept_en = 1'b1;

    // Dime latency: raw sampled first at the next edge, coin visible 8 edges later.
    n_rej = 0;
    coin_raw = 3'b010;
    repeat (7) tick();
    chk("lat_early_valid", int'(coin_valid), 0);
    tick();
    chk("lat_valid", int'(coin_valid), 1);
    chk("lat_cents", int'(coin_cents), 10);
    chk("lat_count", int'(fifo_count), 1);
    repeat (12) tick();
    coin_raw = 3'b000;
    repeat (12) tick();
    chk("dime_count", int'(fifo_count), 1);
    chk("dime_rej", n_rej, 0);
    coin_ready = 1'b1; tick(); coin_ready = 1'b0;

    // Short nickel glitches never reach the debounced state.
    repeat (5) begin
      coin_raw = 3'b001; repeat (3) tick();
      coin_raw = 3'b000; repeat (3) tick();
    end
    repeat (8) tick();
    chk("glitch_count", int'(fifo_count), 0);

    // Jam, clear, then clear coincident with a new jam.
    n_rej = 0;
    insert(3'b101);
    chk("jam_flag", int'(jam_err), 1);
    chk("jam_rej", n_rej, 1);
    chk("jam_count", int'(fifo_count), 0);
    clear_errs();
    chk("jam_clr", int'(jam_err), 0);
    coin_raw = 3'b011;
    repeat (7) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    tick();
    chk("jam_clr_race", int'(jam_err), 1);
    coin_raw = 3'b000;
    repeat (12) tick();
    clear_errs();

    // Overflow on the fifth coin, then drain in order.
    insert(3'b001); insert(3'b010); insert(3'b100); insert(3'b001);
    chk("full_count", int'(fifo_count), 4);
    n_rej = 0;
    insert(3'b010);
    chk("ovf_flag", int'(ovf_err), 1);
    chk("ovf_rej", n_rej, 1);
    chk("ovf_count", int'(fifo_count), 4);
    chk("pop0", int'(coin_cents), 5);
    coin_ready = 1'b1;
    tick(); chk("pop1", int'(coin_cents), 10);
    tick(); chk("pop2", int'(coin_cents), 25);
    tick(); chk("pop3", int'(coin_cents), 5);
    tick(); chk("pop_empty", int'(coin_valid), 0);
    coin_ready = 1'b0;
    clear_errs();
    chk("ovf_clr", int'(ovf_err), 0);

    // Full FIFO with a pop on the same edge as a quarter push.
    insert(3'b001); insert(3'b010); insert(3'b100); insert(3'b001);
    coin_raw = 3'b100;
    repeat (7) tick();
    coin_ready = 1'b1;
    tick();
    coin_ready = 1'b0;
    chk("fullpop_count", int'(fifo_count), 4);
    chk("fullpop_ovf", int'(ovf_err), 0);
    chk("fullpop_head", int'(coin_cents), 10);
    coin_raw = 3'b000;
    repeat (12) tick();
    coin_ready = 1'b1; repeat (5) tick(); coin_ready = 1'b0;

    // Disabled acceptance.
    accept_en = 1'b0;
    n_rej = 0;
    insert(3'b010);
    chk("dis_rej", n_rej, 1);
    chk("dis_count", int'(fifo_count), 0);
    chk("dis_err", int'(jam_err | ovf_err), 0);
    accept_en = 1'b1;

    // Async reset mid-debounce with two coins queued; sensor held through release.
    insert(3'b001); insert(3'b010);
    chk("pre_rst_count", int'(fifo_count), 2);
    coin_raw = 3'b100;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (8) tick();
    chk("held_count", int'(fifo_count), 1);
    chk("held_cents", int'(coin_cents), 25);
    coin_raw = 3'b000;
    repeat (12) tick();
    coin_ready = 1'b1; repeat (3) tick(); coin_ready = 1'b0;

    // Random traffic against the model.
    for (int c = 0; c < 3; c++) run[c] = 0;
    repeat (3000) begin
      for (int c = 0; c < 3; c++) begin
        if (run[c] == 0) begin
          coin_raw[c] = ($urandom_range(0, 2) == 0);
          run[c] = $urandom_range(1, 12);
        end else begin
          run[c]--;
        end
      end
      accept_en  = ($urandom_range(0, 7) != 0);
      coin_ready = ($urandom_range(0, 4) == 0);
      clr_err    = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
